// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
package conv_pkg;

  localparam int KERNEL_PHASES = 3;

  typedef logic [$clog2(KERNEL_PHASES)-1:0] phase_t;

  localparam phase_t PHASE_TOP = 2'd0;
  localparam phase_t PHASE_MID = 2'd1;
  localparam phase_t PHASE_BOT = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MAC0  = 3'd2,
    MAC1  = 3'd3,
    MAC2  = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Row-major output-position counter over the (H-2) x (W-2) valid patch origins.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int H     = 28,
  parameter int W     = 28,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] col_nxt,
  output logic             is_last
);

  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(H - 3);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(W - 3);

  logic [IDX_W-1:0] row_nxt;

  assign is_last = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (clr) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Start/done scheduler for the 3x3 convolution datapath: fetch, three MAC phases, result handoff.
// Optional stall counter port stall_cnt is built only when CONV_SEQ_PERF_EN is defined.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int H     = 28,
  parameter int W     = 28,
  parameter int IDX_W = 5
) (
`ifdef CONV_SEQ_PERF_EN
  output logic [15:0]      stall_cnt,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fetch_req,
  output logic             fetch_full,
  input  logic             fetch_ack,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic [1:0]       mux_sel,
  output logic             acc_en,
  output logic             acc_flush,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] col_nxt;
  logic             is_last;
  logic             accept;
  logic             busy_d, done_d, fetch_req_d, fetch_full_d;
  logic             acc_en_d, acc_flush_d, out_valid_d;
  phase_t           mux_sel_d;

  assign accept = (state == OUT) && out_ready;

  // Wrapping to (0,0) on the last accept leaves row/col cleared in DONE.
  conv_pos_counter #(.H(H), .W(W), .IDX_W(IDX_W)) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept && is_last),
    .adv     (accept && !is_last),
    .row     (row),
    .col     (col),
    .col_nxt (col_nxt),
    .is_last (is_last)
  );

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fetch_req  <= 1'b0;
      fetch_full <= 1'b0;
      mux_sel    <= '0;
      acc_en     <= 1'b0;
      acc_flush  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= busy_d;
      done       <= done_d;
      fetch_req  <= fetch_req_d;
      fetch_full <= fetch_full_d;
      mux_sel    <= mux_sel_d;
      acc_en     <= acc_en_d;
      acc_flush  <= acc_flush_d;
      out_valid  <= out_valid_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (fetch_ack) state_nxt = MAC0;
      MAC0:    state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = is_last ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    fetch_req_d  = 1'b0;
    fetch_full_d = 1'b0;
    mux_sel_d    = PHASE_TOP;
    acc_en_d     = 1'b0;
    acc_flush_d  = 1'b0;
    out_valid_d  = 1'b0;
    case (state_nxt)
      FETCH: begin
        busy_d       = 1'b1;
        fetch_req_d  = 1'b1;
        fetch_full_d = (col_nxt == '0);
      end
      MAC0: begin
        busy_d      = 1'b1;
        acc_en_d    = 1'b1;
        acc_flush_d = 1'b1;
        mux_sel_d   = PHASE_TOP;
      end
      MAC1: begin
        busy_d    = 1'b1;
        acc_en_d  = 1'b1;
        mux_sel_d = PHASE_MID;
      end
      MAC2: begin
        busy_d    = 1'b1;
        acc_en_d  = 1'b1;
        mux_sel_d = PHASE_BOT;
      end
      OUT: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (((state == FETCH && !fetch_ack) || (state == OUT && !out_ready)) &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
